data_memory_ctrl: RTL and testbench



---
 rtl/data_memory_ctrl_if.sv | 30 +++
 rtl/data_memory_ctrl.sv | 137 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory: one request channel and one
// registered response channel, each with its own valid/ready pair.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte/half/word data memory with lane write enables, load extension,
// a single-entry registered response and a saturating fault counter.
module data_memory_ctrl #(
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 32,
  parameter int    CNT_W     = 8,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  data_memory_ctrl_if.slave bus,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              accept;
  logic              out_of_range;
  logic              fault;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_data;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // the response is offered the next cycle and held until rsp_valid & rsp_ready.
  // req_ready is low in reset and while an unconsumed response is held.
  assign bus.req_ready = rst_n & (~rsp_valid_q | bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  assign addr         = bus.req_addr;
  assign idx          = addr[IDX_W+1:2];
  assign lane         = addr[1:0];
  assign out_of_range = (addr >> (IDX_W + 2)) != '0;

  always_comb begin
    fault = out_of_range;
    unique case (bus.req_size)
      2'd0:    fault = out_of_range;
      2'd1:    fault = out_of_range | lane[0];
      2'd2:    fault = out_of_range | (lane != 2'd0);
      default: fault = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = bus.req_wdata;
    unique case (bus.req_size)
      2'd0: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{bus.req_wdata[15:0]}};
      end
      2'd2:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  assign rd_word = mem[idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rd_word;
    unique case (bus.req_size)
      2'd0:    load_data = bus.req_unsigned ? {24'd0, ld_byte}
                                            : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    load_data = bus.req_unsigned ? {16'd0, ld_half}
                                            : {{16{ld_half[15]}}, ld_half};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fault;
      rsp_rdata_d = (fault || bus.req_we) ? 32'd0 : load_data;
      if (fault && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: byte-addressed reference model feeding an
// expected-response queue, drained by an independent response monitor.
module tb_data_memory_ctrl;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 2;
  localparam int W      = 32 + 1 + CNT_W;
  localparam int BOUND  = 60;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   mem_m [4*DEPTH];
  int           cnt_m = 0;
  bit           rand_done = 1'b0;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  data_memory_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_apply(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] val;
    int          nb;
    bit          f;
    f = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)
        || (addr >= 32'(4*DEPTH));
    nb  = 1 << sz;
    val = 32'd0;
    if (f) begin
      if (cnt_m < CNT_MAX) cnt_m++;
      exp_q.push_back({32'd0, 1'b1, CNT_W'(cnt_m)});
    end else if (we) begin
      for (int i = 0; i < nb; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
      exp_q.push_back({32'd0, 1'b0, CNT_W'(cnt_m)});
    end else begin
      for (int i = 0; i < nb; i++) val[8*i +: 8] = mem_m[int'(addr) + i];
      if (sz != 2'd2 && !uns) begin
        for (int j = 8*nb; j < 32; j++) val[j] = val[8*nb-1];
      end
      exp_q.push_back({val, 1'b0, CNT_W'(cnt_m)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n;
    bit accepted;
    n = 0;
    accepted = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    while (!accepted && n < BOUND) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) accepted = 1'b1;
      else n++;
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL req_accept_timeout: addr %h not accepted within %0d cycles", addr, BOUND);
    end else begin
      model_apply(we, sz, uns, addr, wd);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses missing", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rdata %h err %b expected none",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e[W-1 -: 32]);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[CNT_W]});
        chk("err_cnt", 32'(err_cnt), 32'(e[CNT_W-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;
    rst_n            = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // every word gets a known value so later loads never see X
    for (int a = 0; a < DEPTH; a++) do_req(1'b1, 2'd2, 1'b0, 32'(a*4), $urandom());
    drain();

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h80);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h13, 32'hFFFFFFFF);
    do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    drain();
    chk("err_cnt_three_faults", 32'(err_cnt), 32'd3);

    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h8000_0000, 32'h55);
    drain();
    chk("err_cnt_saturated", 32'(err_cnt), 32'(CNT_MAX));

    // backpressure: held load response, next store must wait
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    drain();
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    fork
      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hFFFFFFFF);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
          chk("bp_rsp_rdata", bus.rsp_rdata, 32'h11223344);
          chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    drain();

    // reset with a store presented: nothing commits, counter clears
    rst_n            = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'd2;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h5A5A5A5A;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("midreset_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("midreset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("midreset_err_cnt", 32'(err_cnt), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    cnt_m = 0;
    exp_q.delete();
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    drain();

    // randomized traffic with random response backpressure
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          logic [31:0] a;
          logic [1:0]  sz;
          int          r;
          r  = $urandom_range(0, 9);
          sz = (r == 9) ? 2'd3 : 2'(r % 3);
          if ($urandom_range(0, 15) == 0) a = $urandom() | 32'h400;
          else a = 32'($urandom_range(0, 4*DEPTH-1));
          do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
